branch_sequencer: RTL

Owns the 64-bit program counter and sequences redirects for conditional branches resolved in EX. Evaluates the branch condition from the EX-stage operands and funct3, then drives the PC and the IF/ID flush strobes. Holds a taken redirect across hazard-unit stalls and keeps saturating branch statistics. Sits between the hazard unit, the EX-stage pipeline register and the instruction-fetch stage.

---
 rtl/branch_pkg.sv | 19 +
 rtl/branch_sequencer_if.sv | 36 +++
 rtl/branch_cond_eval.sv | 25 ++
 rtl/branch_sequencer.sv | 109 ++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch sequencer: condition codes, FSM states
// and the sequential fetch increment.
package branch_pkg;

    // funct3 encodings of the supported conditional branches
    localparam logic [2:0] BR_EQ = 3'b000;
    localparam logic [2:0] BR_LT = 3'b100;
    localparam logic [2:0] BR_GT = 3'b101;

    // Byte distance between sequentially fetched instructions
    localparam int unsigned PC_INC = 4;

    // RUN: normal fetch; PEND: a taken redirect is waiting for the stall to clear
    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } seq_state_e;

endpackage

// File: rtl/branch_sequencer_if.sv
// EX-stage / hazard-unit bundle seen by the branch sequencer. The slave side
// is the sequencer itself; the master side is whatever drives the EX operands.
interface branch_sequencer_if #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 32
);

    logic             stall;
    logic             ex_valid;
    logic             ex_is_branch;
    logic [2:0]       ex_funct3;
    logic [XLEN-1:0]  ex_rs1_data;
    logic [XLEN-1:0]  ex_rs2_data;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_imm;

    logic [XLEN-1:0]  pc;
    logic             if_flush;
    logic             id_flush;
    logic             branch_taken;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output stall, ex_valid, ex_is_branch, ex_funct3,
               ex_rs1_data, ex_rs2_data, ex_pc, ex_imm,
        input  pc, if_flush, id_flush, branch_taken, branch_cnt, taken_cnt
    );

    modport slave (
        input  stall, ex_valid, ex_is_branch, ex_funct3,
               ex_rs1_data, ex_rs2_data, ex_pc, ex_imm,
        output pc, if_flush, id_flush, branch_taken, branch_cnt, taken_cnt
    );

endinterface

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator. Operands are compared as unsigned
// values; unknown funct3 codes never take.
module branch_cond_eval
    import branch_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            taken_o
);

    // Select the comparison named by funct3; default keeps the output defined
    always_comb begin
        taken_o = 1'b0;
        case (funct3_i)
            BR_EQ:   taken_o = (a_i == b_i);
            BR_LT:   taken_o = (a_i <  b_i);
            BR_GT:   taken_o = (a_i >  b_i);
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_sequencer.sv
// Program-counter owner. Resolves EX-stage conditional branches, redirects
// fetch, parks a taken redirect while the hazard unit stalls, and keeps
// saturating branch statistics.
module branch_sequencer
    import branch_pkg::*;
#(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    branch_sequencer_if.slave bus
);

    seq_state_e       state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  pendTarget_q, pendTarget_d;
    logic [CNT_W-1:0] branchCnt_q, branchCnt_d;
    logic [CNT_W-1:0] takenCnt_q, takenCnt_d;

    logic             condTrue;
    logic             qualified;
    logic             branchTaken;
    logic             flush;
    logic [XLEN-1:0]  branchTarget;

    branch_cond_eval #(
        .XLEN(XLEN)
    ) u_cond (
        .funct3_i (bus.ex_funct3),
        .a_i      (bus.ex_rs1_data),
        .b_i      (bus.ex_rs2_data),
        .taken_o  (condTrue)
    );

    // Offset is in halfwords; the sum wraps silently at XLEN bits
    assign branchTarget = bus.ex_pc + (bus.ex_imm << 1);

    // State register: reset wins over any pending or same-cycle redirect
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC;
            pendTarget_q <= '0;
            branchCnt_q  <= '0;
            takenCnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pendTarget_q <= pendTarget_d;
            branchCnt_q  <= branchCnt_d;
            takenCnt_q   <= takenCnt_d;
        end
    end

    // Next-state logic: redirect, park the redirect under stall, or step fetch
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pendTarget_d = pendTarget_q;
        branchCnt_d  = branchCnt_q;
        takenCnt_d   = takenCnt_q;

        case (state_q)
            RUN: begin
                if (branchTaken) begin
                    if (bus.stall) begin
                        pendTarget_d = branchTarget;
                        state_d      = PEND;
                    end else begin
                        pc_d = branchTarget;
                    end
                end else if (!bus.stall) begin
                    pc_d = pc_q + XLEN'(PC_INC);
                end
            end
            PEND: begin
                if (!bus.stall) begin
                    pc_d    = pendTarget_q;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        if (qualified && (branchCnt_q != '1)) begin
            branchCnt_d = branchCnt_q + CNT_W'(1);
        end
        if (branchTaken && (takenCnt_q != '1)) begin
            takenCnt_d = takenCnt_q + CNT_W'(1);
        end
    end

    // Output logic: EX inputs only count in RUN; flushes stay up while parked
    always_comb begin
        qualified   = bus.ex_valid && bus.ex_is_branch && (state_q == RUN) && !reset;
        branchTaken = qualified && condTrue;
        flush       = !reset && (branchTaken || (state_q == PEND));
    end

    assign bus.pc           = pc_q;
    assign bus.if_flush     = flush;
    assign bus.id_flush     = flush;
    assign bus.branch_taken = branchTaken;
    assign bus.branch_cnt   = branchCnt_q;
    assign bus.taken_cnt    = takenCnt_q;

endmodule
